// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass, zero register, pending-write scoreboard and sequential clear.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  output logic [NREGS-1:0]      busy_vec
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic              run, we;
  assign run = state == RUN;
  assign we = run && !clear_req && wr_en && wr_addr != '0;
  assign busy_vec = busy;
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
      ready <= 1'b0;
    end else if (!run) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else if (clear_req) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
      ready <= 1'b0;
    end else begin
      busy <= busy_nxt;
    end
  // Storage carries no reset: the clear walk zeroes it one entry per cycle.
  always_ff @(posedge clk)
    if (!run) mem[cnt] <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a = rd_addr[g*AW +: AW];
    assign hit = BYPASS != 0 && wr_en && wr_addr == a;
    assign rd_data[g*XLEN +: XLEN] = (!run || a == '0) ? '0 : hit ? wr_data : mem[a];
    assign rd_busy[g] = run && a != '0 && !hit && busy[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp (bypass/2-port and no-bypass/4-port instances) against a behavioural model.
module tb_regfile_mp;
  logic         clk, reset, clear_req, wr_en, alloc_en;
  logic [4:0]   wr_addr, alloc_addr;
  logic [31:0]  wr_data;
  logic [9:0]   ra2;
  logic [63:0]  rd2;
  logic [1:0]   rb2;
  logic [31:0]  bv2, bv4;
  logic         ready2, ready4;
  logic [19:0]  ra4;
  logic [127:0] rd4;
  logic [3:0]   rb4;
  int checks = 0, errors = 0;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready2),
    .rd_addr(ra2), .rd_data(rd2), .rd_busy(rb2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(bv2));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(4), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready4),
    .rd_addr(ra4), .rd_data(rd4), .rd_busy(rb4),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(bv4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: clearing blanks everything at once; m_clr counts the cycles the clear still keeps ready low
  logic [31:0] m_mem [32];
  logic [31:0] m_busy = '0;
  int m_clr = 32;
  initial for (int i = 0; i < 32; i++) m_mem[i] = '0;

  task automatic m_start_clear();
    m_clr = 32;
    m_busy = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
  endtask

  always @(posedge clk or posedge reset)
    if (reset) m_start_clear();
    else if (m_clr > 0) m_clr--;
    else if (clear_req) m_start_clear();
    else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end

  function automatic logic e_ready();
    return !reset && m_clr == 0;
  endfunction

  function automatic logic [31:0] e_rd(logic [4:0] a, bit byp);
    if (!e_ready() || a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic e_bz(logic [4:0] a, bit byp);
    if (!e_ready() || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready_b", 32'(ready2), 32'(e_ready()));
    chk("ready_n", 32'(ready4), 32'(e_ready()));
    chk("busyvec_b", bv2, m_busy);
    chk("busyvec_n", bv4, m_busy);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_b%0d", p), rd2[p*32 +: 32], e_rd(ra2[p*5 +: 5], 1'b1));
      chk($sformatf("rbusy_b%0d", p), 32'(rb2[p]), 32'(e_bz(ra2[p*5 +: 5], 1'b1)));
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rd_n%0d", p), rd4[p*32 +: 32], e_rd(ra4[p*5 +: 5], 1'b0));
      chk($sformatf("rbusy_n%0d", p), 32'(rb4[p]), 32'(e_bz(ra4[p*5 +: 5], 1'b0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_wait(string n);
    for (int i = 0; i < 32; i++) begin
      chk(n, 32'(ready2), 32'h0);
      tick();
    end
    chk({n, "_rise"}, 32'(ready2), 32'h1);
    chk({n, "_rise_n"}, 32'(ready4), 32'h1);
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; ra2 = '0; ra4 = '0;
    repeat (3) tick();
    reset = 1'b0;
    clear_wait("init_clear");
    chk("init_busyvec", bv2, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ra2 = {5'(31 - a), 5'(a)};
      ra4 = {5'(a), 5'(31 - a), 5'(a), 5'(31 - a)};
      tick();
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; ra2 = {5'd0, 5'd5}; ra4 = {15'd0, 5'd5};
    #1 chk("byp_same", rd2[31:0], 32'hDEADBEEF);
    chk("nobyp_same", rd4[31:0], 32'h0);
    tick();
    wr_en = 1'b0;
    #1 chk("nobyp_next", rd4[31:0], 32'hDEADBEEF);
    chk("byp_next", rd2[31:0], 32'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; alloc_en = 1'b1; alloc_addr = 5'd0; ra2 = '0;
    tick();
    wr_en = 1'b0; alloc_en = 1'b0;
    #1 chk("x0_p0", rd2[31:0], 32'h0);
    chk("x0_p1", rd2[63:32], 32'h0);
    chk("x0_busy", 32'(bv2[0]), 32'h0);
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    alloc_en = 1'b0; ra2 = {5'd0, 5'd7}; ra4 = {15'd0, 5'd7};
    #1 chk("x7_busy", 32'(rb2[0]), 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #1 chk("x7_busy_byp", 32'(rb2[0]), 32'h0);
    chk("x7_busy_nobyp", 32'(rb4[0]), 32'h1);
    chk("x7_data_byp", rd2[31:0], 32'h55);
    tick();
    wr_en = 1'b0;
    #1 chk("x7_busyvec", 32'(bv2[7]), 32'h0);
    alloc_en = 1'b1; alloc_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    alloc_en = 1'b0; wr_en = 1'b0;
    #1 chk("x9_set_wins", bv2, 32'h0000_0200);
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
      tick();
    end
    wr_en = 1'b0;
    ra4 = {5'd31, 5'd29, 5'd17, 5'd3};
    #1 chk("p4_0", rd4[31:0], 32'd3);
    chk("p4_1", rd4[63:32], 32'd17);
    chk("p4_2", rd4[95:64], 32'd29);
    chk("p4_3", rd4[127:96], 32'd31);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wr_en = (i == 5); wr_addr = 5'd3; wr_data = 32'hAA;
      chk("sw_clear", 32'(ready2), 32'h0);
      tick();
    end
    wr_en = 1'b0;
    chk("sw_clear_rise", 32'(ready2), 32'h1);
    ra2 = {5'd31, 5'd3};
    #1 chk("clr_x3", rd2[31:0], 32'h0);
    chk("clr_x31", rd2[63:32], 32'h0);
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    #1 reset = 1'b1;
    #1 chk("rst_ready", 32'(ready2), 32'h0);
    chk("rst_rd", rd2[31:0], 32'h0);
    tick();
    reset = 1'b0;
    clear_wait("rst_clear");
    ra2 = {5'd2, 5'd2};
    #1 chk("rst_x2", rd2[31:0], 32'h0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
